// File: rtl/dlau_result_reader.sv
// Drains a programmed number of FP16 results from the jFIFO read port onto a valid/ready stream with last/done.
// Optional macro DLAU_RELU_EN zeroes sign-set words at capture.
module dlau_result_reader #(
  parameter int WIDTH = 16,
  parameter int TILE  = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] tile_len,
  input  logic             fifo_empty,
  output logic             fifo_rn,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [CNT_W-1:0] TILE_C = CNT_W'(TILE);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] len, issued, sent, len_clamp;
  logic             inflight;
  logic [1:0]       occ;
  logic [WIDTH-1:0] buf0, buf1, cap_word, head;
  logic             beat, last_beat, in_run;

  assign len_clamp = (tile_len > TILE_C) ? TILE_C : tile_len;

`ifdef DLAU_RELU_EN
  assign cap_word = fifo_dout[WIDTH-1] ? '0 : fifo_dout;
`else
  assign cap_word = fifo_dout;
`endif

  // The word arriving this cycle is visible straight away when the buffer is empty,
  // so the first beat needs no extra register stage.
  assign head      = (occ != 2'd0) ? buf0 : cap_word;
  assign in_run    = (state == RUN);
  assign beat      = out_valid && out_ready;
  assign last_beat = beat && (sent == len - ONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (len == '0 || last_beat) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = in_run;
    done      = (state == FIN);
    out_valid = in_run && (occ != 2'd0 || inflight);
    out_data  = out_valid ? head : '0;
    out_last  = out_valid && (sent == len - ONE);
    // Stored plus in-flight words never exceed the two buffer slots.
    fifo_rn   = !reset && in_run && (issued < len) && !fifo_empty &&
                (({1'b0, occ} + {2'b00, inflight}) < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len      <= '0;
      issued   <= '0;
      sent     <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= fifo_rn;
      if (state == IDLE && start) begin
        len    <= len_clamp;
        issued <= '0;
        sent   <= '0;
      end
      if (fifo_rn) issued <= issued + ONE;
      if (beat)    sent   <= sent + ONE;
      case (occ)
        2'd0: begin
          if (inflight && !beat) begin
            buf0 <= cap_word;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (beat) begin
            if (inflight) buf0 <= cap_word;
            else          occ  <= 2'd0;
          end else if (inflight) begin
            buf1 <= cap_word;
            occ  <= 2'd2;
          end
        end
        default: begin
          if (beat) begin
            buf0 <= buf1;
            occ  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlau_result_reader.sv
// Bench for dlau_result_reader: behavioural jFIFO, queue-based reference stream, table rows plus corner sequences.
`timescale 1ns/1ps
module tb_dlau_result_reader;
  localparam int WIDTH = 16;
  localparam int TILE  = 32;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset, start, fifo_empty, fifo_rn, out_valid, out_ready, out_last, busy, done;
  logic [CNT_W-1:0] tile_len;
  logic [WIDTH-1:0] fifo_dout, out_data;

  dlau_result_reader #(.WIDTH(WIDTH), .TILE(TILE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .tile_len(tile_len),
    .fifo_empty(fifo_empty), .fifo_rn(fifo_rn), .fifo_dout(fifo_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int pop_cnt = 0, beat_cnt = 0, beat_idx = 0, cur_n = 0, done_cnt = 0, cyc = 0, rdy_mode = 0;
  logic [3:0]       rdy_pat = 4'hF;
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] ref_q[$];
  logic             stall_prev = 1'b0, prev_last = 1'b0;
  logic [WIDTH-1:0] prev_data = '0, exp_w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] w);
`ifdef DLAU_RELU_EN
    return w[WIDTH-1] ? 16'h0000 : w;
`else
    return w;
`endif
  endfunction

  function automatic int clamp_len(input int l);
    return (l > TILE) ? TILE : l;
  endfunction

  task automatic push_word(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    ref_q.push_back(relu(w));
    fifo_empty = 1'b0;
  endtask

  task automatic flush();
    fifo_q.delete();
    ref_q.delete();
    fifo_empty = 1'b1;
  endtask

  // jFIFO read port: dout is updated the cycle after a read-enable cycle.
  always @(posedge clk) begin
    logic rn_s;
    rn_s = fifo_rn;
    #1;
    if (rn_s) begin
      pop_cnt++;
      if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else               out_ready = rdy_pat[cyc[1:0]];
  end

  // Stream monitor: every accepted beat is compared with the reference word stream.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (fifo_rn) chk("rn_when_empty", 32'(fifo_empty), 32'd0);
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        chk("occupancy_le2", 32'(pop_cnt - beat_cnt <= 2), 32'd1);
        if (ref_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", out_data);
        end else begin
          exp_w = ref_q.pop_front();
          chk("beat_data", 32'(out_data), 32'(exp_w));
        end
        chk("beat_last", 32'(out_last), 32'(beat_idx == cur_n - 1));
        beat_idx++;
        beat_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) done_cnt++;
    end
  end

  task automatic do_start(input int len);
    @(posedge clk); #1;
    start    = 1'b1;
    tile_len = CNT_W'(len);
    cur_n    = clamp_len(len);
    beat_idx = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
  endtask

  task automatic clear_counts();
    pop_cnt  = 0;
    beat_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic run_transfer(input int len, input int exp_beats, input int exp_rn, input string nm);
    clear_counts();
    do_start(len);
    wait_done(nm);
    @(negedge clk);
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    chk({nm, "_done_1cyc"}, 32'(done), 32'd0);
    chk({nm, "_valid_after"}, 32'(out_valid), 32'd0);
    chk({nm, "_beats"}, 32'(beat_cnt), 32'(exp_beats));
    chk({nm, "_rn_count"}, 32'(pop_cnt), 32'(exp_rn));
    chk({nm, "_done_count"}, 32'(done_cnt), 32'd1);
    flush();
  endtask

  typedef struct {
    int         len;
    int         npre;
    int         src;      // 0 fixed list, 1 constant 3C00, 2 random
    int         off;
    int         rmode;    // 0 pattern, 1 random
    logic [3:0] pat;
    int         exp_beats;
    int         exp_rn;
  } row_t;

  row_t tbl[6];
  logic [WIDTH-1:0] fixed_w[7] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'hC000, 16'h8000, 16'h4000};

  initial begin
    reset = 1'b1; start = 1'b0; tile_len = '0; fifo_empty = 1'b1; fifo_dout = '0; out_ready = 1'b1;

    tbl[0] = '{len: 4,  npre: 4,  src: 0, off: 0, rmode: 0, pat: 4'b1111, exp_beats: 4,  exp_rn: 4};
    tbl[1] = '{len: 32, npre: 32, src: 1, off: 0, rmode: 0, pat: 4'b1001, exp_beats: 32, exp_rn: 32};
    tbl[2] = '{len: 40, npre: 40, src: 2, off: 0, rmode: 0, pat: 4'b1111, exp_beats: 32, exp_rn: 32};
    tbl[3] = '{len: 3,  npre: 3,  src: 0, off: 4, rmode: 0, pat: 4'b1111, exp_beats: 3,  exp_rn: 3};
    tbl[4] = '{len: 1,  npre: 2,  src: 2, off: 0, rmode: 0, pat: 4'b0110, exp_beats: 1,  exp_rn: 1};
    tbl[5] = '{len: 9,  npre: 12, src: 2, off: 0, rmode: 1, pat: 4'b1111, exp_beats: 9,  exp_rn: 9};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rn", 32'(fifo_rn), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // First-beat latency: valid two cycles after the start cycle.
    for (int i = 0; i < 4; i++) push_word(fixed_w[i]);
    clear_counts();
    @(posedge clk); #1;
    start = 1'b1; tile_len = CNT_W'(2); cur_n = 2; beat_idx = 0;
    @(negedge clk);
    chk("lat_c0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("lat_c1_busy", 32'(busy), 32'd1);
    chk("lat_c1_rn", 32'(fifo_rn), 32'd1);
    chk("lat_c1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_c2_valid", 32'(out_valid), 32'd1);
    wait_done("lat");
    @(negedge clk);
    chk("lat_rn_count", 32'(pop_cnt), 32'd2);
    flush();

    for (int r = 0; r < 6; r++) begin
      rdy_mode = tbl[r].rmode;
      rdy_pat  = tbl[r].pat;
      for (int i = 0; i < tbl[r].npre; i++) begin
        case (tbl[r].src)
          0:       push_word(fixed_w[tbl[r].off + i]);
          1:       push_word(16'h3C00);
          default: push_word(16'($urandom));
        endcase
      end
      run_transfer(tbl[r].len, tbl[r].exp_beats, tbl[r].exp_rn, $sformatf("row%0d", r));
    end

    rdy_mode = 1;
    for (int t = 0; t < 6; t++) begin
      int l;
      l = $urandom_range(1, 40);
      for (int i = 0; i < clamp_len(l) + $urandom_range(0, 3); i++) push_word(16'($urandom));
      run_transfer(l, clamp_len(l), clamp_len(l), $sformatf("rand%0d", t));
    end
    rdy_mode = 0; rdy_pat = 4'hF;

    // Zero length: no reads, done two cycles after the start cycle.
    push_word(16'h1234); push_word(16'h5678);
    clear_counts();
    @(posedge clk); #1;
    start = 1'b1; tile_len = '0; cur_n = 0; beat_idx = 0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0_c1_busy", 32'(busy), 32'd1);
    chk("len0_c1_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("len0_c2_done", 32'(done), 32'd1);
    chk("len0_c2_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("len0_c3_done", 32'(done), 32'd0);
    chk("len0_rn_count", 32'(pop_cnt), 32'd0);
    flush();

    // Underrun: two words, stall, third word arrives later.
    push_word(16'h4A00); push_word(16'h4B00);
    clear_counts();
    do_start(3);
    for (int n = 0; n < 100 && beat_cnt < 2; n++) @(negedge clk);
    chk("ur_two_beats", 32'(beat_cnt), 32'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("ur_stall_valid", 32'(out_valid), 32'd0);
      chk("ur_stall_rn", 32'(fifo_rn), 32'd0);
    end
    @(posedge clk); #1;
    push_word(16'h4C00);
    wait_done("ur");
    @(negedge clk);
    chk("ur_beats", 32'(beat_cnt), 32'd3);
    chk("ur_rn_count", 32'(pop_cnt), 32'd3);
    chk("ur_done_count", 32'(done_cnt), 32'd1);
    flush();

    // A start pulse while busy must not restart or shorten the transfer.
    for (int i = 0; i < 6; i++) push_word(16'($urandom));
    clear_counts();
    do_start(6);
    @(posedge clk); #1;
    start = 1'b1; tile_len = CNT_W'(2);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("mid");
    @(negedge clk);
    chk("mid_beats", 32'(beat_cnt), 32'd6);
    chk("mid_rn_count", 32'(pop_cnt), 32'd6);
    chk("mid_done_count", 32'(done_cnt), 32'd1);
    flush();

    // Reset after five of eight beats aborts cleanly.
    for (int i = 0; i < 8; i++) push_word(16'($urandom));
    clear_counts();
    do_start(8);
    for (int n = 0; n < 100 && beat_cnt < 5; n++) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstm_rn_forced", 32'(fifo_rn), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstm_valid", 32'(out_valid), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_rn", 32'(fifo_rn), 32'd0);
    repeat (3) @(negedge clk);
    chk("rstm_no_done", 32'(done_cnt), 32'd0);
    flush();
    push_word(16'h3800); push_word(16'hB800);
    run_transfer(2, 2, 2, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dlau_result_reader.md
Name: dlau_result_reader

Overview:
- Drain side of the DLAU output path. On `start` it pops a programmed number of FP16 results from the result FIFO (jFIFO read port) and presents them on a valid/ready stream to the host or next stage, marking the final beat.
- Replaces the hand-driven `rn` / DATAOUT checks used in bring-up with a backpressure-safe reader. It holds a 2-entry skid buffer, so full throughput is sustained when `out_ready` stays high.

Parameters:
- WIDTH, 16, data word width (FP16 half precision)
- TILE, 32, maximum results per transfer
- CNT_W, 6, width of length and beat counters; must satisfy 2^CNT_W > TILE

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a transfer when idle
- tile_len  input  CNT_W  number of results to read; sampled on accepted start
- fifo_empty  input  1  jFIFO empty flag
- fifo_rn  output  1  jFIFO read enable
- fifo_dout  input  WIDTH  jFIFO DATAOUT; valid the cycle after a cycle with fifo_rn=1
- out_valid  output  1  stream data valid
- out_ready  input  1  downstream accept
- out_data  output  WIDTH  result word
- out_last  output  1  high with the final beat of a transfer
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (reset=1 at edge): state=IDLE; counters and buffer cleared.
  - Outputs: out_valid=0, out_last=0, out_data=0, busy=0, done=0.
  - fifo_rn is forced to 0 combinationally while reset=1.
  - Reset mid-transfer aborts the transfer: an in-flight pop is discarded and no done pulse is produced.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 latches len = min(tile_len, TILE), then goes to RUN, with busy=1 from the next cycle.
  - If len==0: go to FIN directly, issue no reads.
  - start while busy is ignored.
- RUN, issue side:
  - fifo_rn = issued<len && !fifo_empty && (occupancy + inflight) < 2.
  - fifo_rn never asserts when fifo_empty=1.
  - inflight = fifo_rn registered one cycle.
- RUN, capture side:
  - In the cycle after fifo_rn=1, fifo_dout is written into the skid buffer (2-entry FIFO, head-first ordering).
- RUN, output side:
  - out_valid = buffer non-empty; out_data = buffer head.
  - A beat transfers when out_valid && out_ready.
  - Capture and beat transfer in the same cycle are allowed; occupancy is unchanged.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
- Counters:
  - issued increments on each fifo_rn=1.
  - sent increments on each beat.
  - out_last = out_valid && (sent == len-1).
- RUN→FIN: on the beat where sent == len-1.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. A start during FIN is ignored.
- Latency: first out_valid is 2 cycles after start, given a non-empty FIFO and idle state (start edge → RUN with fifo_rn=1 → capture → out_valid).
- Throughput: 1 beat/cycle with out_ready=1 and a non-empty FIFO.
- FIFO underrun: if fifo_empty rises mid-transfer, reads stall. out_valid drops once the buffer drains, and the transfer resumes with no lost or duplicated data.
- Data passes unmodified (bit-exact), except under the optional feature below.

Optional Feature:
- Macro DLAU_RELU_EN.
- When defined: the captured word is replaced by 16'h0000 if its sign bit [WIDTH-1] is 1. This covers negatives and -0.0; NaNs with sign=1 are also zeroed. Replacement happens at capture, with no added latency.
- When undefined: words pass bit-exact and no comparison logic is present.

Test Plan:
- Basic drain:
  - Stimulus: FIFO preloaded with 16'h3C00, 16'h4000, 16'h4200, 16'h4400; tile_len=4; start; out_ready=1.
  - Required: 4 consecutive beats in that order; out_last only on 16'h4400; done pulse 1 cycle after the last beat; busy low afterwards; exactly 4 fifo_rn pulses.
- Backpressure:
  - Stimulus: FIFO preloaded with 32 words of 16'h3C00; tile_len=32; out_ready toggles 1,0,0,1 repeatedly.
  - Required: all 32 beats delivered; out_data stable while stalled; occupancy never exceeds 2; fifo_rn count = 32.
- Underrun:
  - Stimulus: FIFO holds 2 words (16'h4A00, 16'h4B00); tile_len=3; third word 16'h4C00 written 10 cycles later.
  - Required: 2 beats, then out_valid=0 with no rn while fifo_empty=1; 16'h4C00 then delivered with out_last=1.
- Edge lengths:
  - tile_len=0 → no fifo_rn, done pulse 2 cycles after start.
  - tile_len=40 → clamped to 32 beats.
  - A start pulse mid-transfer is ignored.
- Reset mid-transfer:
  - Stimulus: assert reset after 5 of 8 beats.
  - Required: next cycle out_valid=0, busy=0, fifo_rn=0, no done pulse; a new start with tile_len=2 works normally.
- DLAU_RELU_EN:
  - Stimulus: words 16'hC000 (-2.0), 16'h8000 (-0.0), 16'h4000.
  - Required with macro: 16'h0000, 16'h0000, 16'h4000.
  - Required without macro: 16'hC000, 16'h8000, 16'h4000.
